mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 No parameters; widths come from the shared defines (address 64, data 64, size 2, resp 2).
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_valid_i  input  1  fetch request; held high until if_ready_o.
REQ-005 if_ready_o  output  1  one-cycle fetch completion pulse.
REQ-006 if_addr_i  input  64  fetch address.
REQ-007 if_size_i  input  2  fetch size code.
REQ-008 if_data_read_o  output  64  fetch data; valid only while if_ready_o=1.
REQ-009 if_resp_o  output  2  fetch response; valid only while if_ready_o=1.
REQ-010 mem_valid_i  input  1  load/store request; held high until mem_ready_o.
REQ-011 mem_ready_o  output  1  one-cycle load/store completion pulse.
REQ-012 mem_req_i  input  1  `REQ_READ or `REQ_WRITE.
REQ-013 mem_addr_i  input  64  load/store address.
REQ-014 mem_size_i  input  2  load/store size code.
REQ-015 mem_data_write_i  input  64  store data.
REQ-016 mem_data_read_o  output  64  load data; valid only while mem_ready_o=1.
REQ-017 mem_resp_o  output  2  load/store response; valid only while mem_ready_o=1.
REQ-018 rw_valid_o  output  1  request to the AXI bridge.
REQ-019 rw_ready_i  input  1  bridge completion pulse.
REQ-020 rw_req_o, rw_addr_o, rw_size_o, data_write_o  output  1/64/2/64  latched request fields.
REQ-021 data_read_i, rw_resp_i  input  64/2  bridge read data and response.

Function
REQ-022 FSM states: IDLE, BUSY_IF, BUSY_MEM.
REQ-023 IDLE, single request pending:
- move to the matching BUSY state;
- latch that requester's req/addr/size/wdata into the rw_* registers;
- the fetch path latches req = `REQ_READ and wdata = 0.
REQ-024 IDLE, both requests pending: round-robin on a 1-bit last_grant register; grant the requester not granted last.
REQ-025 last_grant updates on each grant (0 = fetch, 1 = mem).
REQ-026 rw_valid_o = 1 exactly in the BUSY states, so it rises one cycle after the grant decision.
REQ-027 rw_* fields are stable for the whole BUSY state and do not follow input changes.
REQ-028 BUSY_x with rw_ready_i=1, same cycle, combinationally:
- assert x_ready_o;
- route data_read_i and rw_resp_i to x's outputs;
- next state IDLE.
REQ-029 The non-granted requester's ready stays 0.
REQ-030 Minimum spacing between grants is one IDLE cycle; a requester still valid in that IDLE cycle is re-arbitrated.
REQ-031 The response datapath of each requester reads 0 when that requester is not being completed.
REQ-032 rw_ready_i in IDLE is ignored: no ready pulse, no state change.
REQ-033 A requester dropping valid during its own BUSY state is a protocol violation; the transaction still completes and its ready pulse is still issued.
REQ-034 Only one outstanding bridge transaction at any time.

Reset
REQ-035 Reset low immediately forces, irrespective of clock:
- state = IDLE, last_grant = 1 (fetch wins first tie);
- rw_valid_o = 0, rw_* registers = 0;
- all ready outputs = 0, all read-data/resp outputs = 0.
REQ-036 Reset mid-transaction abandons it; no ready pulse is issued.

Structure
REQ-037 `REQ_READ/`REQ_WRITE, the size codes and the width macros come from defines.v.
REQ-038 FSM state encodings are local parameters.
REQ-039 Single flat module, no sub-module.

Verification
REQ-040 Fetch-only read at addr 0x8000_0000, bridge returns 0x1234 after 3 cycles -> if_ready_o pulses once with data 0x1234; rw_req_o = `REQ_READ.
REQ-041 Fetch and mem valid in the same cycle after reset -> fetch granted first, then mem after one IDLE cycle.
REQ-042 Both valid continuously for 6 transactions -> grants alternate IF, MEM, IF, MEM...
REQ-043 Store of 0xDEAD_BEEF to 0x8000_0100 with inputs changed during BUSY -> bridge sees the original latched values throughout.
REQ-044 Reset low while BUSY_MEM -> all outputs 0 without a clock edge; no mem_ready_o pulse after release.
REQ-045 rw_ready_i pulsed while IDLE -> no ready pulse and no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, request/size codes, grant encoding and FSM state type for the
// instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 2;
    localparam int RESP_W = 2;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [SIZE_W-1:0] SIZE_BYTE  = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF  = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD  = 2'd2;
    localparam logic [SIZE_W-1:0] SIZE_DWORD = 2'd3;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single AXI bridge port.
// One outstanding transaction; round-robin on ties; completion routed combinationally.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic [SIZE_W-1:0] if_size_i,
    output logic [DATA_W-1:0] if_data_read_o,
    output logic [RESP_W-1:0] if_resp_o,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [SIZE_W-1:0] mem_size_i,
    input  logic [DATA_W-1:0] mem_data_write_i,
    output logic [DATA_W-1:0] mem_data_read_o,
    output logic [RESP_W-1:0] mem_resp_o,
    output logic              rw_valid_o,
    input  logic              rw_ready_i,
    output logic              rw_req_o,
    output logic [ADDR_W-1:0] rw_addr_o,
    output logic [SIZE_W-1:0] rw_size_o,
    output logic [DATA_W-1:0] data_write_o,
    input  logic [DATA_W-1:0] data_read_i,
    input  logic [RESP_W-1:0] rw_resp_i
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              rw_req_q, rw_req_d;
    logic [ADDR_W-1:0] rw_addr_q, rw_addr_d;
    logic [SIZE_W-1:0] rw_size_q, rw_size_d;
    logic [DATA_W-1:0] rw_wdata_q, rw_wdata_d;
    logic              if_done_s;
    logic              mem_done_s;

    // State, grant history and latched bridge request; last_grant resets to mem so fetch wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_MEM;
            rw_req_q     <= 1'b0;
            rw_addr_q    <= {ADDR_W{1'b0}};
            rw_size_q    <= {SIZE_W{1'b0}};
            rw_wdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rw_req_q     <= rw_req_d;
            rw_addr_q    <= rw_addr_d;
            rw_size_q    <= rw_size_d;
            rw_wdata_q   <= rw_wdata_d;
        end
    end

    // Arbitration and next-state; request fields are captured only on a grant
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rw_req_d     = rw_req_q;
        rw_addr_d    = rw_addr_q;
        rw_size_d    = rw_size_q;
        rw_wdata_d   = rw_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_valid_i && (!mem_valid_i || (last_grant_q == GRANT_MEM))) begin
                    state_d      = ST_BUSY_IF;
                    last_grant_d = GRANT_IF;
                    rw_req_d     = REQ_READ;
                    rw_addr_d    = if_addr_i;
                    rw_size_d    = if_size_i;
                    rw_wdata_d   = {DATA_W{1'b0}};
                end else if (mem_valid_i) begin
                    state_d      = ST_BUSY_MEM;
                    last_grant_d = GRANT_MEM;
                    rw_req_d     = mem_req_i;
                    rw_addr_d    = mem_addr_i;
                    rw_size_d    = mem_size_i;
                    rw_wdata_d   = mem_data_write_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_IF: begin
                if (rw_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY_IF;
                end
            end
            ST_BUSY_MEM: begin
                if (rw_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY_MEM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completion is same-cycle with the bridge pulse; response buses read zero otherwise
    always_comb begin
        if_done_s       = (state_q == ST_BUSY_IF)  && rw_ready_i;
        mem_done_s      = (state_q == ST_BUSY_MEM) && rw_ready_i;
        if_ready_o      = if_done_s;
        mem_ready_o     = mem_done_s;
        if_data_read_o  = {DATA_W{1'b0}};
        if_resp_o       = {RESP_W{1'b0}};
        mem_data_read_o = {DATA_W{1'b0}};
        mem_resp_o      = {RESP_W{1'b0}};
        if (if_done_s) begin
            if_data_read_o = data_read_i;
            if_resp_o      = rw_resp_i;
        end else begin
            if_data_read_o = {DATA_W{1'b0}};
            if_resp_o      = {RESP_W{1'b0}};
        end
        if (mem_done_s) begin
            mem_data_read_o = data_read_i;
            mem_resp_o      = rw_resp_i;
        end else begin
            mem_data_read_o = {DATA_W{1'b0}};
            mem_resp_o      = {RESP_W{1'b0}};
        end
    end

    assign rw_valid_o   = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);
    assign rw_req_o     = rw_req_q;
    assign rw_addr_o    = rw_addr_q;
    assign rw_size_o    = rw_size_q;
    assign data_write_o = rw_wdata_q;

endmodule
